// File: rtl/pico_bus_pkg.sv
// Shared definitions for the PicoRV32 bus fabric: slot numbering, region
// compare constants, FSM state type and the address decode function.
package pico_bus_pkg;

  localparam int unsigned NUM_SLOTS = 10;

  localparam logic [3:0] SLOT_PROGMEM = 4'd0;
  localparam logic [3:0] SLOT_RAM     = 4'd1;
  localparam logic [3:0] SLOT_PERIPH0 = 4'd2;

  localparam logic [11:0] PROGMEM_REGION = 12'h001;
  localparam logic [11:0] RAM_REGION     = 12'h000;
  localparam logic [3:0]  PERIPH_TOP     = 4'h0;
  localparam logic [3:0]  PERIPH_FIRST   = 4'h4;
  localparam logic [3:0]  PERIPH_LAST    = 4'hB;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } state_e;

  // Returns {hit, slot}; progmem is tested before RAM so the first match wins.
  function automatic logic [4:0] decode(input logic [31:0] addr);
    logic [4:0] res;
    res = '0;
    if (addr[31:20] == PROGMEM_REGION) begin
      res = {1'b1, SLOT_PROGMEM};
    end else if (addr[31:20] == RAM_REGION) begin
      res = {1'b1, SLOT_RAM};
    end else if ((addr[31:28] == PERIPH_TOP) &&
                 (addr[27:24] >= PERIPH_FIRST) &&
                 (addr[27:24] <= PERIPH_LAST)) begin
      res = {1'b1, addr[27:24] - PERIPH_FIRST + SLOT_PERIPH0};
    end
    return res;
  endfunction

endpackage

// File: rtl/pico_bus_decode.sv
// Combinational address decoder: slot select plus the progmem write error.
module pico_bus_decode
  import pico_bus_pkg::*;
#(
  parameter bit ROM_WR_ERR = 1'b1
) (
  input  logic [31:0] addr_i,
  input  logic [3:0]  wstrb_i,
  output logic        hit_o,
  output logic [3:0]  slot_o,
  output logic        rom_wr_err_o
);

  logic [4:0] dec;

  always_comb begin
    dec          = decode(addr_i);
    hit_o        = dec[4];
    slot_o       = dec[3:0];
    rom_wr_err_o = ROM_WR_ERR && dec[4] && (dec[3:0] == SLOT_PROGMEM) &&
                   (wstrb_i != 4'h0);
  end

endmodule

// File: rtl/pico_bus_fabric.sv
// Single-master PicoRV32 interconnect: registers a request, drives one slave
// valid, waits for its ready (or a timeout) and returns a one-cycle ready pulse.
module pico_bus_fabric
  import pico_bus_pkg::*;
#(
  parameter int unsigned TIMEOUT    = 64,
  parameter logic [31:0] ERR_DATA   = 32'hDEAD_BEEF,
  parameter bit          ROM_WR_ERR = 1'b1
) (
  input  logic                    clk,
  input  logic                    rstn,
  input  logic                    cpu_valid,
  input  logic                    cpu_instr,
  input  logic [31:0]             cpu_addr,
  input  logic [31:0]             cpu_wdata,
  input  logic [3:0]              cpu_wstrb,
  output logic                    cpu_ready,
  output logic [31:0]             cpu_rdata,
  output logic                    bus_err,
  output logic [NUM_SLOTS-1:0]    s_valid,
  output logic [31:0]             s_addr,
  output logic [31:0]             s_wdata,
  output logic [3:0]              s_wstrb,
  input  logic [NUM_SLOTS-1:0]    s_ready,
  input  logic [NUM_SLOTS*32-1:0] s_rdata
);

  localparam int unsigned          CW       = $clog2(TIMEOUT);
  localparam logic [CW-1:0]        CNT_LAST = CW'(TIMEOUT - 1);
  localparam logic [CW-1:0]        CNT_MAX  = '1;
  localparam logic [NUM_SLOTS-1:0] SV_ONE   = NUM_SLOTS'(1);

  state_e                state_q, state_d;
  logic                  err_q, err_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [3:0]            slot_q, slot_d;
  logic [NUM_SLOTS-1:0]  s_valid_q, s_valid_d;
  logic [31:0]           s_addr_q, s_addr_d;
  logic [31:0]           s_wdata_q, s_wdata_d;
  logic [3:0]            s_wstrb_q, s_wstrb_d;
  logic [31:0]           cpu_rdata_q, cpu_rdata_d;

  logic                  dec_hit;
  logic [3:0]            dec_slot;
  logic                  dec_rom_wr_err;
  logic                  sel_ready;
  logic [31:0]           sel_rdata;
  logic                  unused_instr;

  assign unused_instr = cpu_instr;

  pico_bus_decode #(
    .ROM_WR_ERR(ROM_WR_ERR)
  ) u_decode (
    .addr_i      (cpu_addr),
    .wstrb_i     (cpu_wstrb),
    .hit_o       (dec_hit),
    .slot_o      (dec_slot),
    .rom_wr_err_o(dec_rom_wr_err)
  );

  // Only the latched slot's handshake is observed; all other ready bits are ignored.
  assign sel_ready = s_ready[slot_q];
  assign sel_rdata = s_rdata[{slot_q, 5'd0} +: 32];

  always_comb begin
    state_d     = state_q;
    err_d       = err_q;
    cnt_d       = cnt_q;
    slot_d      = slot_q;
    s_valid_d   = s_valid_q;
    s_addr_d    = s_addr_q;
    s_wdata_d   = s_wdata_q;
    s_wstrb_d   = s_wstrb_q;
    cpu_rdata_d = cpu_rdata_q;
    unique case (state_q)
      IDLE: begin
        if (cpu_valid) begin
          if (dec_hit && !dec_rom_wr_err) begin
            s_addr_d  = cpu_addr;
            s_wdata_d = cpu_wdata;
            s_wstrb_d = cpu_wstrb;
            s_valid_d = SV_ONE << dec_slot;
            slot_d    = dec_slot;
            cnt_d     = '0;
            err_d     = 1'b0;
            state_d   = WAIT;
          end else begin
            cpu_rdata_d = ERR_DATA;
            err_d       = 1'b1;
            state_d     = RESP;
          end
        end
      end
      WAIT: begin
        if (sel_ready) begin
          cpu_rdata_d = sel_rdata;
          s_valid_d   = '0;
          err_d       = 1'b0;
          state_d     = RESP;
        end else if (cnt_q == CNT_LAST) begin
          cpu_rdata_d = ERR_DATA;
          s_valid_d   = '0;
          err_d       = 1'b1;
          state_d     = RESP;
        end else if (cnt_q != CNT_MAX) begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q     <= IDLE;
      err_q       <= 1'b0;
      cnt_q       <= '0;
      slot_q      <= '0;
      s_valid_q   <= '0;
      s_addr_q    <= '0;
      s_wdata_q   <= '0;
      s_wstrb_q   <= '0;
      cpu_rdata_q <= '0;
    end else begin
      state_q     <= state_d;
      err_q       <= err_d;
      cnt_q       <= cnt_d;
      slot_q      <= slot_d;
      s_valid_q   <= s_valid_d;
      s_addr_q    <= s_addr_d;
      s_wdata_q   <= s_wdata_d;
      s_wstrb_q   <= s_wstrb_d;
      cpu_rdata_q <= cpu_rdata_d;
    end
  end

  assign cpu_ready = (state_q == RESP);
  assign bus_err   = (state_q == RESP) && err_q;
  assign cpu_rdata = cpu_rdata_q;
  assign s_valid   = s_valid_q;
  assign s_addr    = s_addr_q;
  assign s_wdata   = s_wdata_q;
  assign s_wstrb   = s_wstrb_q;

endmodule
